ram_arbiter: RTL and testbench

- Two-port round-robin arbiter/sequencer that shares one 16x8 RAM between requesters A and B.
- Serialises single-word read/write transactions, drives the RAM's read/write strobes and addresses, and captures read data.
- Returns data to each requester with a one-cycle ack pulse.
- Sits between the two client blocks and the RAM instance.

---
 rtl/ram_arbiter_if.sv | 51 +++++
 rtl/ram_arbiter.sv | 147 ++++++++++++++
 tb/tb_ram_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared RAM.
interface ram_arbiter_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
);
    // requester A
    logic          req_a;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a;
    logic          ack_a;
    logic [DW-1:0] rdata_a;
    // requester B
    logic          req_b;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b;
    logic          ack_b;
    logic [DW-1:0] rdata_b;
    // status
    logic          err;
    logic          busy;
    // RAM side
    logic          ram_read;
    logic          ram_write;
    logic [AW-1:0] ram_raddr;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_read_ready;

    // arbiter view
    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        output ack_a, rdata_a, ack_b, rdata_b,
        output err, busy,
        output ram_read, ram_write, ram_raddr, ram_waddr, ram_wdata,
        input  ram_rdata, ram_read_ready
    );

    // requester/RAM environment view
    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        input  ack_a, rdata_a, ack_b, rdata_b,
        input  err, busy,
        input  ram_read, ram_write, ram_raddr, ram_waddr, ram_wdata,
        output ram_rdata, ram_read_ready
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM between requesters A and B; one
// single-word transaction at a time, acked with a one-cycle pulse.
module ram_arbiter #(
    parameter int unsigned AW      = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic         clock,
    input  logic         reset,
    ram_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t        state, state_d;
    logic          sel, sel_d;          // 0 = A, 1 = B
    logic          last, last_d;        // port granted most recently
    logic          we_r, we_d;
    logic [AW-1:0] addr_r, addr_d;
    logic [DW-1:0] wdata_r, wdata_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          err_r, err_d;
    logic          ack_a_r, ack_a_d;
    logic          ack_b_r, ack_b_d;
    logic [DW-1:0] rdata_a_r, rdata_a_d;
    logic [DW-1:0] rdata_b_r, rdata_b_d;
    logic          busy_r, busy_d;
    logic          rd_r, rd_d;
    logic          wr_r, wr_d;
    logic          grant;

    // State and registered outputs; async reset abandons any transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            cnt       <= '0;
            err_r     <= 1'b0;
            ack_a_r   <= 1'b0;
            ack_b_r   <= 1'b0;
            rdata_a_r <= '0;
            rdata_b_r <= '0;
            busy_r    <= 1'b0;
            rd_r      <= 1'b0;
            wr_r      <= 1'b0;
        end else begin
            state     <= state_d;
            sel       <= sel_d;
            last      <= last_d;
            we_r      <= we_d;
            addr_r    <= addr_d;
            wdata_r   <= wdata_d;
            cnt       <= cnt_d;
            err_r     <= err_d;
            ack_a_r   <= ack_a_d;
            ack_b_r   <= ack_b_d;
            rdata_a_r <= rdata_a_d;
            rdata_b_r <= rdata_b_d;
            busy_r    <= busy_d;
            rd_r      <= rd_d;
            wr_r      <= wr_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d   = state;
        sel_d     = sel;
        last_d    = last;
        we_d      = we_r;
        addr_d    = addr_r;
        wdata_d   = wdata_r;
        cnt_d     = cnt;
        err_d     = err_r;
        rdata_a_d = rdata_a_r;
        rdata_b_d = rdata_b_r;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        grant     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    // Under contention the port not served last wins.
                    grant   = (bus.req_a && bus.req_b) ? ~last : bus.req_b;
                    sel_d   = grant;
                    we_d    = grant ? bus.we_b    : bus.we_a;
                    addr_d  = grant ? bus.addr_b  : bus.addr_a;
                    wdata_d = grant ? bus.wdata_b : bus.wdata_a;
                    wr_d    = we_d;
                    rd_d    = ~we_d;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_r) begin
                    state_d = ACK;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.ram_read_ready) begin
                    if (sel) rdata_b_d = bus.ram_rdata;
                    else     rdata_a_d = bus.ram_rdata;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (cnt_d == CW'(TIMEOUT)) begin
                        err_d = 1'b1;
                        if (sel) rdata_b_d = '0;
                        else     rdata_a_d = '0;
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                last_d  = sel;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ack_a_d = (state_d == ACK) && !sel;
        ack_b_d = (state_d == ACK) &&  sel;
        busy_d  = (state_d != IDLE);
    end

    assign bus.ack_a     = ack_a_r;
    assign bus.ack_b     = ack_b_r;
    assign bus.rdata_a   = rdata_a_r;
    assign bus.rdata_b   = rdata_b_r;
    assign bus.err       = err_r;
    assign bus.busy      = busy_r;
    assign bus.ram_read  = rd_r;
    assign bus.ram_write = wr_r;
    assign bus.ram_raddr = addr_r;
    assign bus.ram_waddr = addr_r;
    assign bus.ram_wdata = wdata_r;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level scoreboard checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ram_arbiter;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM model: data and ready registered one edge after ram_read
    logic [DW-1:0] ram_mem [16];
    bit stall = 1'b0;
    always @(posedge clock) begin
        bus.ram_read_ready <= bus.ram_read && !stall;
        bus.ram_rdata      <= ram_mem[bus.ram_raddr];
        if (bus.ram_write) ram_mem[bus.ram_waddr] <= bus.ram_wdata;
    end

    // Requester drivers fed from per-port command queues
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;
    cmd_t q_a[$], q_b[$];
    bit   active[2];
    int   last_lat[2], ack_cnt[2];
    logic last_err[2];
    logic [DW-1:0] last_rd[2];
    bit   ack_order[$];
    int   ack_cyc[$];
    logic [DW-1:0] ack_rd[$];

    task automatic drive(input bit p, input logic v, input cmd_t c);
        if (p) begin
            bus.req_b = v; bus.we_b = c.we; bus.addr_b = c.addr; bus.wdata_b = c.wdata;
        end else begin
            bus.req_a = v; bus.we_a = c.we; bus.addr_a = c.addr; bus.wdata_a = c.wdata;
        end
    endtask

    task automatic run_port(input bit p);
        cmd_t c;
        int   raise, n;
        logic ak;
        c = '0;
        forever begin
            @(posedge clock); #1;
            while ((p ? q_b.size() : q_a.size()) != 0) begin
                active[p] = 1'b1;
                c = p ? q_b.pop_front() : q_a.pop_front();
                drive(p, 1'b1, c);
                raise = cyc;
                n = 0;
                do begin
                    @(negedge clock);
                    n++;
                    ak = p ? bus.ack_b : bus.ack_a;
                end while (!ak && n < 40);
                if (!ak) check(p ? "ack_wait_b" : "ack_wait_a", 32'(0), 32'(1));
                last_lat[p] = cyc - raise;
                last_err[p] = bus.err;
                last_rd[p]  = p ? bus.rdata_b : bus.rdata_a;
                ack_cnt[p]++;
                ack_order.push_back(p);
                ack_cyc.push_back(cyc);
                ack_rd.push_back(last_rd[p]);
                @(posedge clock); #1;
            end
            drive(p, 1'b0, c);
            active[p] = 1'b0;
        end
    endtask

    initial run_port(1'b0);
    initial run_port(1'b1);

    // Scoreboard: predicts each cycle's outputs from grant decisions
    typedef struct packed {
        logic          busy, ack_a, ack_b, err, rd, wr, ld_a, ld_b;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] val;
    } exp_t;
    exp_t          sched [16];
    logic [DW-1:0] mdl_mem [16];
    logic [DW-1:0] mdl_ra = '0, mdl_rb = '0;
    bit            mdl_last = 1'b1;
    int            free_at = 0;

    always @(negedge clock) begin : model
        exp_t          e;
        bit            g, mwe;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        int            nw, k;
        k = cyc;
        if (reset) begin
            check("rst_busy",  32'(bus.busy),      32'(0));
            check("rst_ack",   32'({bus.ack_a, bus.ack_b}), 32'(0));
            check("rst_err",   32'(bus.err),       32'(0));
            check("rst_strb",  32'({bus.ram_read, bus.ram_write}), 32'(0));
            check("rst_rdata", 32'({bus.rdata_a, bus.rdata_b}), 32'(0));
            for (int i = 0; i < 16; i++) sched[i] = '0;
            mdl_ra = '0; mdl_rb = '0; mdl_last = 1'b1; free_at = 0;
        end else begin
            e = sched[k % 16];
            sched[k % 16] = '0;
            if (e.ld_a) mdl_ra = e.val;
            if (e.ld_b) mdl_rb = e.val;
            check("busy",      32'(bus.busy),      32'(e.busy));
            check("ack_a",     32'(bus.ack_a),     32'(e.ack_a));
            check("ack_b",     32'(bus.ack_b),     32'(e.ack_b));
            check("err",       32'(bus.err),       32'(e.err));
            check("ram_read",  32'(bus.ram_read),  32'(e.rd));
            check("ram_write", 32'(bus.ram_write), 32'(e.wr));
            check("rdata_a",   32'(bus.rdata_a),   32'(mdl_ra));
            check("rdata_b",   32'(bus.rdata_b),   32'(mdl_rb));
            if (e.rd) check("ram_raddr", 32'(bus.ram_raddr), 32'(e.addr));
            if (e.wr) begin
                check("ram_waddr", 32'(bus.ram_waddr), 32'(e.addr));
                check("ram_wdata", 32'(bus.ram_wdata), 32'(e.wdata));
            end
            // a request present while idle is granted at the coming edge
            if (k >= free_at && (bus.req_a || bus.req_b)) begin
                g   = (bus.req_a && bus.req_b) ? !mdl_last : bus.req_b;
                mdl_last = g;
                mwe = g ? bus.we_b    : bus.we_a;
                ma  = g ? bus.addr_b  : bus.addr_a;
                md  = g ? bus.wdata_b : bus.wdata_a;
                sched[(k + 1) % 16].busy  = 1'b1;
                sched[(k + 1) % 16].rd    = !mwe;
                sched[(k + 1) % 16].wr    = mwe;
                sched[(k + 1) % 16].addr  = ma;
                sched[(k + 1) % 16].wdata = md;
                if (mwe) begin
                    mdl_mem[ma] = md;
                    nw = 0;
                end else begin
                    nw = stall ? int'(TO) : 1;
                end
                for (int j = 0; j < nw; j++) sched[(k + 2 + j) % 16].busy = 1'b1;
                sched[(k + 2 + nw) % 16].busy  = 1'b1;
                sched[(k + 2 + nw) % 16].ack_a = !g;
                sched[(k + 2 + nw) % 16].ack_b = g;
                if (!mwe) begin
                    sched[(k + 2 + nw) % 16].err  = stall;
                    sched[(k + 2 + nw) % 16].ld_a = !g;
                    sched[(k + 2 + nw) % 16].ld_b = g;
                    sched[(k + 2 + nw) % 16].val  = stall ? '0 : mdl_mem[ma];
                end
                free_at = k + 3 + nw;
            end
        end
    end

    // Strobe monitor for the directed checks
    int            wr_cnt = 0, rd_cnt = 0;
    logic [AW-1:0] mon_waddr, mon_raddr;
    logic [DW-1:0] mon_wdata;
    always @(negedge clock) begin
        if (!reset && bus.ram_write) begin
            wr_cnt++; mon_waddr = bus.ram_waddr; mon_wdata = bus.ram_wdata;
        end
        if (!reset && bus.ram_read) begin
            rd_cnt++; mon_raddr = bus.ram_raddr;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || active[0] || active[1] || bus.busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) check("idle_timeout", 32'(1), 32'(0));
        @(negedge clock);
    endtask

    function automatic cmd_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d;
        return c;
    endfunction

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : stim
        int  base_w, base_r, base_ack, n;
        bit  exp_ord [6];
        logic [DW-1:0] exp_rd [3];
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_rd  = '{8'h11, 8'h22, 8'h33};
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy",  32'(bus.busy),    32'(0));
        check("reset_ack",   32'({bus.ack_a, bus.ack_b}), 32'(0));
        check("reset_raddr", 32'(bus.ram_raddr), 32'(0));
        check("reset_wdata", 32'(bus.ram_wdata), 32'(0));
        reset = 1'b0;

        // A writes 3 = 0x5A, then reads it back
        base_w = wr_cnt;
        q_a.push_back(mk(1'b1, 4'd3, 8'h5A));
        wait_idle();
        check("wr_latency", 32'(last_lat[0]), 32'(2));
        check("wr_count",   32'(wr_cnt - base_w), 32'(1));
        check("wr_waddr",   32'(mon_waddr), 32'(3));
        check("wr_wdata",   32'(mon_wdata), 32'h5A);
        base_r = rd_cnt;
        q_a.push_back(mk(1'b0, 4'd3, 8'h00));
        wait_idle();
        check("rd_latency", 32'(last_lat[0]), 32'(3));
        check("rd_count",   32'(rd_cnt - base_r), 32'(1));
        check("rd_raddr",   32'(mon_raddr), 32'(3));
        check("rd_data",    32'(last_rd[0]), 32'h5A);
        check("rd_err",     32'(last_err[0]), 32'(0));

        // Contention with both requests held through reset
        @(posedge clock); #1;
        reset = 1'b1;
        ack_order.delete(); ack_rd.delete();
        q_a.push_back(mk(1'b1, 4'd7, 8'h77));
        q_a.push_back(mk(1'b0, 4'd7, 8'h00));
        q_a.push_back(mk(1'b1, 4'd8, 8'h88));
        q_b.push_back(mk(1'b0, 4'd3, 8'h00));
        q_b.push_back(mk(1'b1, 4'd9, 8'h99));
        q_b.push_back(mk(1'b0, 4'd9, 8'h00));
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        wait_idle();
        check("rr_count", 32'(ack_order.size()), 32'(6));
        if (ack_order.size() == 6) begin
            for (int i = 0; i < 6; i++) check("rr_order", 32'(ack_order[i]), 32'(exp_ord[i]));
            check("rr_rdata_b3", 32'(ack_rd[1]), 32'h5A);
            check("rr_rdata_a7", 32'(ack_rd[2]), 32'h77);
            check("rr_rdata_b9", 32'(ack_rd[5]), 32'h99);
        end

        // Lone requester B: back-to-back writes then reads
        ack_order.delete(); ack_cyc.delete(); ack_rd.delete();
        q_b.push_back(mk(1'b1, 4'd0, 8'h11));
        q_b.push_back(mk(1'b1, 4'd1, 8'h22));
        q_b.push_back(mk(1'b1, 4'd2, 8'h33));
        wait_idle();
        check("lone_w_count", 32'(ack_order.size()), 32'(3));
        if (ack_order.size() == 3) begin
            for (int i = 0; i < 3; i++) check("lone_w_port", 32'(ack_order[i]), 32'(1));
            check("lone_w_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'(3));
            check("lone_w_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'(3));
        end
        ack_order.delete(); ack_cyc.delete(); ack_rd.delete();
        for (int i = 0; i < 3; i++) q_b.push_back(mk(1'b0, AW'(i), 8'h00));
        wait_idle();
        check("lone_r_count", 32'(ack_rd.size()), 32'(3));
        if (ack_rd.size() == 3) begin
            for (int i = 0; i < 3; i++) check("lone_r_data", 32'(ack_rd[i]), 32'(exp_rd[i]));
            check("lone_r_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'(4));
        end

        // Timeout: RAM never answers
        stall = 1'b1;
        q_a.push_back(mk(1'b0, 4'd0, 8'h00));
        wait_idle();
        check("to_latency", 32'(last_lat[0]), 32'(6));
        check("to_err",     32'(last_err[0]), 32'(1));
        check("to_rdata",   32'(last_rd[0]),  32'(0));
        stall = 1'b0;
        q_a.push_back(mk(1'b0, 4'd1, 8'h00));
        wait_idle();
        check("post_to_err",   32'(last_err[0]), 32'(0));
        check("post_to_rdata", 32'(last_rd[0]),  32'h22);
        check("post_to_lat",   32'(last_lat[0]), 32'(3));

        // Reset while waiting on the RAM; held request is re-served
        stall = 1'b1;
        base_ack = ack_cnt[0];
        q_a.push_back(mk(1'b0, 4'd2, 8'h00));
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.ram_read && n < 20);
        check("rw_saw_issue", 32'(bus.ram_read), 32'(1));
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        check("rw_busy",  32'(bus.busy),  32'(0));
        check("rw_ack",   32'({bus.ack_a, bus.ack_b}), 32'(0));
        check("rw_err",   32'(bus.err),   32'(0));
        check("rw_raddr", 32'(bus.ram_raddr), 32'(0));
        check("rw_rdata", 32'(bus.rdata_a), 32'(0));
        stall = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        wait_idle();
        check("rw_acks",  32'(ack_cnt[0] - base_ack), 32'(1));
        check("rw_data",  32'(last_rd[0]),  32'h33);
        check("rw_err2",  32'(last_err[0]), 32'(0));

        // Cross-port coherency
        q_b.push_back(mk(1'b1, 4'd15, 8'hC3));
        wait_idle();
        q_a.push_back(mk(1'b0, 4'd15, 8'h00));
        wait_idle();
        check("xp_rdata_a", 32'(last_rd[0]), 32'hC3);
        check("xp_idle",    32'(bus.busy),   32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
